// File: rtl/action_issue_ctrl_if.sv
// Handshake/data bundle between the upstream stage/lookup, action_issue_ctrl and action_engine.
// master = traffic source and sink side, slave = the issue controller.
interface action_issue_ctrl_if #(
    parameter int unsigned PHV_LEN = 1124,
    parameter int unsigned ACT_W   = 625
);
    logic [PHV_LEN-1:0] phv_in;
    logic               phv_valid_in;
    logic               phv_ready_out;
    logic [ACT_W-1:0]   action_in;
    logic               action_valid_in;
    logic               act_ready_out;
    logic               stall_in;
    logic [PHV_LEN-1:0] phv_out;
    logic               phv_valid_out;
    logic [ACT_W-1:0]   action_out;
    logic               action_valid_out;
    logic [1:0]         err_drop_out;

    modport master (
        output phv_in, phv_valid_in, action_in, action_valid_in, stall_in,
        input  phv_ready_out, act_ready_out, phv_out, phv_valid_out, action_out,
        input  action_valid_out, err_drop_out
    );

    modport slave (
        input  phv_in, phv_valid_in, action_in, action_valid_in, stall_in,
        output phv_ready_out, act_ready_out, phv_out, phv_valid_out, action_out,
        output action_valid_out, err_drop_out
    );
endinterface

// File: rtl/action_issue_ctrl.sv
// Pairs buffered PHVs with buffered action words and issues them together; orphans are dropped
// after TIMEOUT_CYC cycles. Optional counters enabled by defining ACT_ISSUE_STATS_EN.
module action_issue_ctrl #(
    parameter int unsigned STAGE       = 0,
    parameter int unsigned PHV_LEN     = 1124,
    parameter int unsigned ACT_LEN     = 25,
    parameter int unsigned ACT_NUM     = 25,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    action_issue_ctrl_if.slave  bus,
`ifdef ACT_ISSUE_STATS_EN
    output logic [31:0]         issue_cnt_out,
    output logic [15:0]         drop_phv_cnt_out,
    output logic [15:0]         drop_act_cnt_out,
`endif
    output logic [7:0]          err_stage_out
);
    localparam int unsigned ActW = ACT_LEN * ACT_NUM;
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        StIdle, StWaitAct, StWaitPhv, StPaired, StDropPhv, StDropAct
    } state_e;

    state_e state_q, state_d;
    logic [15:0] timer_q, timer_d;

    logic [PHV_LEN-1:0] phv_mem [FIFO_DEPTH];
    logic [ActW-1:0]    act_mem [FIFO_DEPTH];
    logic [PtrW-1:0]    phv_wr_q, phv_rd_q, act_wr_q, act_rd_q;
    logic [CntW-1:0]    phv_cnt_q, act_cnt_q;

    logic phv_full, act_full, phv_push, act_push, phv_pop, act_pop;
    logic ph, ah, issue, drop_phv, drop_act;

    logic [PHV_LEN-1:0] phv_out_q;
    logic [ActW-1:0]    act_out_q;
    logic               valid_q;
    logic [1:0]         err_q;

    assign phv_full = (phv_cnt_q == CntW'(FIFO_DEPTH));
    assign act_full = (act_cnt_q == CntW'(FIFO_DEPTH));
    // A push into a full FIFO is refused even when a pop frees a slot in the same cycle.
    assign phv_push = bus.phv_valid_in & ~phv_full;
    assign act_push = bus.action_valid_in & ~act_full;
    assign ph = (phv_cnt_q != '0);
    assign ah = (act_cnt_q != '0);

    function automatic state_e idle_next(input logic p, input logic a);
        if (p && a) return StPaired;
        if (p)      return StWaitAct;
        if (a)      return StWaitPhv;
        return StIdle;
    endfunction

    always_comb begin
        state_d  = state_q;
        phv_pop  = 1'b0;
        act_pop  = 1'b0;
        issue    = 1'b0;
        drop_phv = 1'b0;
        drop_act = 1'b0;
        case (state_q)
            StIdle: state_d = idle_next(ph, ah);
            StWaitAct: begin
                if (ah)                                   state_d = StPaired;
                else if (timer_q == 16'(TIMEOUT_CYC - 1)) state_d = StDropPhv;
            end
            StWaitPhv: begin
                if (ph)                                   state_d = StPaired;
                else if (timer_q == 16'(TIMEOUT_CYC - 1)) state_d = StDropAct;
            end
            StPaired: begin
                if (!bus.stall_in) begin
                    phv_pop = 1'b1;
                    act_pop = 1'b1;
                    issue   = 1'b1;
                    state_d = idle_next(phv_cnt_q > CntW'(1), act_cnt_q > CntW'(1));
                end
            end
            StDropPhv: begin
                phv_pop  = 1'b1;
                drop_phv = 1'b1;
                state_d  = idle_next(phv_cnt_q > CntW'(1), ah);
            end
            StDropAct: begin
                act_pop  = 1'b1;
                drop_act = 1'b1;
                state_d  = idle_next(ph, act_cnt_q > CntW'(1));
            end
            default: state_d = StIdle;
        endcase

        timer_d = '0;
        if ((state_d == state_q) && ((state_q == StWaitAct) || (state_q == StWaitPhv))) begin
            timer_d = timer_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            phv_wr_q  <= '0;
            phv_rd_q  <= '0;
            act_wr_q  <= '0;
            act_rd_q  <= '0;
            phv_cnt_q <= '0;
            act_cnt_q <= '0;
            phv_out_q <= '0;
            act_out_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            if (phv_push) phv_wr_q <= phv_wr_q + PtrW'(1);
            if (phv_pop)  phv_rd_q <= phv_rd_q + PtrW'(1);
            if (act_push) act_wr_q <= act_wr_q + PtrW'(1);
            if (act_pop)  act_rd_q <= act_rd_q + PtrW'(1);
            phv_cnt_q <= phv_cnt_q + CntW'(phv_push) - CntW'(phv_pop);
            act_cnt_q <= act_cnt_q + CntW'(act_push) - CntW'(act_pop);
            valid_q   <= issue;
            err_q     <= {drop_act, drop_phv};
            if (issue) begin
                phv_out_q <= phv_mem[phv_rd_q];
                act_out_q <= act_mem[act_rd_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (phv_push) phv_mem[phv_wr_q] <= bus.phv_in;
        if (act_push) act_mem[act_wr_q] <= bus.action_in;
    end

    assign bus.phv_ready_out    = ~phv_full;
    assign bus.act_ready_out    = ~act_full;
    assign bus.phv_out          = phv_out_q;
    assign bus.action_out       = act_out_q;
    assign bus.phv_valid_out    = valid_q;
    assign bus.action_valid_out = valid_q;
    assign bus.err_drop_out     = err_q;
    assign err_stage_out        = 8'(STAGE);

`ifdef ACT_ISSUE_STATS_EN
    logic [31:0] issue_cnt_q;
    logic [15:0] drop_phv_cnt_q, drop_act_cnt_q;

    // Counters saturate rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt_q    <= '0;
            drop_phv_cnt_q <= '0;
            drop_act_cnt_q <= '0;
        end else begin
            if (issue && (issue_cnt_q != '1))          issue_cnt_q    <= issue_cnt_q + 32'd1;
            if (drop_phv && (drop_phv_cnt_q != '1))    drop_phv_cnt_q <= drop_phv_cnt_q + 16'd1;
            if (drop_act && (drop_act_cnt_q != '1))    drop_act_cnt_q <= drop_act_cnt_q + 16'd1;
        end
    end

    assign issue_cnt_out    = issue_cnt_q;
    assign drop_phv_cnt_out = drop_phv_cnt_q;
    assign drop_act_cnt_out = drop_act_cnt_q;
`endif
endmodule

// File: tb/tb_action_issue_ctrl.sv
// Scoreboard bench for action_issue_ctrl: directed stimulus pushes expected issues/drops,
// a negedge monitor pops and compares whenever the DUT presents an issue or drop pulse.
module tb_action_issue_ctrl;
    localparam int unsigned PL = 64;
    localparam int unsigned AL = 8;
    localparam int unsigned AN = 4;
    localparam int unsigned AW = AL * AN;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] err_stage;
    always #5 clk = ~clk;

    action_issue_ctrl_if #(.PHV_LEN(PL), .ACT_W(AW)) bus ();

    action_issue_ctrl #(
        .STAGE(3), .PHV_LEN(PL), .ACT_LEN(AL), .ACT_NUM(AN), .FIFO_DEPTH(4), .TIMEOUT_CYC(12)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .err_stage_out(err_stage)
    );

    int checks = 0;
    int failures = 0;
    logic [PL-1:0] exp_phv_q[$];
    logic [AW-1:0] exp_act_q[$];
    logic [1:0]    exp_drop_q[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit vp, input logic [PL-1:0] p, input bit va,
                        input logic [AW-1:0] a);
        bus.phv_valid_in    = vp;
        bus.phv_in          = p;
        bus.action_valid_in = va;
        bus.action_in       = a;
        @(posedge clk);
        #1;
        bus.phv_valid_in    = 1'b0;
        bus.action_valid_in = 1'b0;
    endtask

    task automatic expect_pair(input logic [PL-1:0] p, input logic [AW-1:0] a);
        exp_phv_q.push_back(p);
        exp_act_q.push_back(a);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_phv_q.size() != 0 || exp_drop_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (exp_phv_q.size() != 0 || exp_drop_q.size() != 0) begin
            fail(name);
            exp_phv_q.delete();
            exp_act_q.delete();
            exp_drop_q.delete();
        end
        tick(3);
    endtask

    // Monitor: every issue and every drop pulse must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            chk("valid_match", 64'(bus.action_valid_out), 64'(bus.phv_valid_out));
            if (bus.phv_valid_out) begin
                if (exp_phv_q.size() == 0) fail("unexpected_issue");
                else begin
                    chk("issue_phv", 64'(bus.phv_out), 64'(exp_phv_q.pop_front()));
                    chk("issue_act", 64'(bus.action_out), 64'(exp_act_q.pop_front()));
                end
            end
            if (bus.err_drop_out != 2'b00) begin
                if (exp_drop_q.size() == 0) fail("unexpected_drop");
                else chk("drop_code", 64'(bus.err_drop_out), 64'(exp_drop_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.phv_in          = '0;
        bus.phv_valid_in    = 1'b0;
        bus.action_in       = '0;
        bus.action_valid_in = 1'b0;
        bus.stall_in        = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_phv_ready", 64'(bus.phv_ready_out), 64'd1);
        chk("rst_act_ready", 64'(bus.act_ready_out), 64'd1);
        chk("rst_phv_valid", 64'(bus.phv_valid_out), 64'd0);
        chk("rst_act_valid", 64'(bus.action_valid_out), 64'd0);
        chk("rst_phv_out", 64'(bus.phv_out), 64'd0);
        chk("rst_act_out", 64'(bus.action_out), 64'd0);
        chk("rst_err_drop", 64'(bus.err_drop_out), 64'd0);
        chk("err_stage", 64'(err_stage), 64'd3);
        @(posedge clk);
        #1 rst = 1'b0;

        // Same-cycle pair: accepted at edge N, issue visible in cycle N+2
        expect_pair(64'hA1A1_0000_0000_0001, 32'hAA00_0001);
        send(1'b1, 64'hA1A1_0000_0000_0001, 1'b1, 32'hAA00_0001);
        @(negedge clk);
        chk("lat_n0", 64'(bus.phv_valid_out), 64'd0);
        @(negedge clk);
        chk("lat_n1", 64'(bus.phv_valid_out), 64'd0);
        @(negedge clk);
        chk("lat_n2", 64'(bus.phv_valid_out), 64'd1);
        drain("t1_drain", 20);

        // Action arrives 10 cycles after its PHV
        expect_pair(64'hB2B2_0000_0000_0002, 32'hBB00_0002);
        send(1'b1, 64'hB2B2_0000_0000_0002, 1'b0, '0);
        tick(9);
        send(1'b0, '0, 1'b1, 32'hBB00_0002);
        drain("t2_drain", 30);

        // Lone PHV times out and is dropped exactly once
        exp_drop_q.push_back(2'b01);
        send(1'b1, 64'hC3C3_0000_0000_0003, 1'b0, '0);
        drain("t3_drain", 40);

        // Partner lands one cycle too late: PHV dropped, then the lone action dropped
        exp_drop_q.push_back(2'b01);
        exp_drop_q.push_back(2'b10);
        send(1'b1, 64'hD4D4_0000_0000_0004, 1'b0, '0);
        tick(12);
        send(1'b0, '0, 1'b1, 32'hDD00_0004);
        drain("t3b_drain", 60);

        // Partner lands in the expiry cycle: pairing wins, nothing dropped
        expect_pair(64'hE5E5_0000_0000_0005, 32'hEE00_0005);
        send(1'b1, 64'hE5E5_0000_0000_0005, 1'b0, '0);
        tick(11);
        send(1'b0, '0, 1'b1, 32'hEE00_0005);
        drain("t5_drain", 30);

        // Stall: fifth push refused, then four back-to-back ordered issues
        bus.stall_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_pair(64'h4000 + 64'(i), 32'h400 + 32'(i));
            send(1'b1, 64'h4000 + 64'(i), 1'b1, 32'h400 + 32'(i));
        end
        @(negedge clk);
        chk("full_phv_ready", 64'(bus.phv_ready_out), 64'd0);
        chk("full_act_ready", 64'(bus.act_ready_out), 64'd0);
        send(1'b1, 64'h4004, 1'b1, 32'h404);
        bus.stall_in = 1'b0;
        @(negedge clk);
        chk("stall_hold", 64'(bus.phv_valid_out), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("b2b_issue", 64'(bus.phv_valid_out), 64'd1);
        end
        @(negedge clk);
        chk("no_fifth", 64'(bus.phv_valid_out), 64'd0);
        drain("t4_drain", 20);
        chk("t4_phv_ready", 64'(bus.phv_ready_out), 64'd1);

        // Reset while three pairs are queued and one issue is on the outputs
        bus.stall_in = 1'b1;
        expect_pair(64'h6000, 32'h600);
        for (int i = 0; i < 4; i++) send(1'b1, 64'h6000 + 64'(i), 1'b1, 32'h600 + 32'(i));
        bus.stall_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("inflight", 64'(bus.phv_valid_out), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_phv_valid", 64'(bus.phv_valid_out), 64'd0);
        chk("arst_act_valid", 64'(bus.action_valid_out), 64'd0);
        chk("arst_phv_out", 64'(bus.phv_out), 64'd0);
        chk("arst_act_out", 64'(bus.action_out), 64'd0);
        chk("arst_phv_ready", 64'(bus.phv_ready_out), 64'd1);
        chk("arst_act_ready", 64'(bus.act_ready_out), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(20);
        @(negedge clk);
        chk("post_rst_phv_ready", 64'(bus.phv_ready_out), 64'd1);
        chk("post_rst_act_ready", 64'(bus.act_ready_out), 64'd1);
        chk("post_rst_valid", 64'(bus.phv_valid_out), 64'd0);
        if (exp_phv_q.size() != 0 || exp_drop_q.size() != 0) fail("leftover_expect");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
